// File: rtl/ram_filler.sv
// RAM fill engine: writes an inclusive address range with one of four data
// patterns, one write per acknowledged enabled cycle, with abort support.
module ram_filler #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] M_CONST = MODE_W'(0);
  localparam logic [MODE_W-1:0] M_INC   = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_ADDRX = MODE_W'(2);

  // Pattern generator; only the low DATA_W bits of address and index matter.
  function automatic logic [DATA_W-1:0] fill_value(
    input logic [MODE_W-1:0] md,
    input logic [DATA_W-1:0] pat,
    input logic [DATA_W-1:0] a_lo,
    input logic [DATA_W-1:0] idx_lo
  );
    logic [DATA_W-1:0] v;
    case (md)
      M_CONST: v = pat;
      M_INC:   v = pat + idx_lo;
      M_ADDRX: v = a_lo ^ pat;
      default: v = a_lo[0] ? ~pat : pat;
    endcase
    return v;
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] idx_inc;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign idx_inc  = idx_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    end_d     = end_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          if (start) begin
            if (start_addr <= end_addr) begin
              end_d     = end_addr;
              mode_d    = mode;
              pattern_d = pattern;
              idx_d     = '0;
              addr_d    = start_addr;
              data_d    = fill_value(mode, pattern, start_addr[DATA_W-1:0], '0);
              wr_d      = 1'b1;
              busy_d    = 1'b1;
              state_d   = S_WRITE;
            end else begin
              // Empty range reports as an abort without touching memory.
              done_d    = 1'b1;
              aborted_d = 1'b1;
              state_d   = S_ABORT;
            end
          end
        end

        S_WRITE: begin
          if (abort) begin
            wr_d      = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            state_d   = S_ABORT;
          end else if (ack) begin
            // Compare before incrementing so an all-ones end never wraps.
            if (addr_q == end_q) begin
              wr_d      = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              aborted_d = 1'b0;
              state_d   = S_FINISH;
            end else begin
              addr_d = addr_inc;
              idx_d  = idx_inc;
              data_d = fill_value(mode_q, pattern_q, addr_inc[DATA_W-1:0],
                                  idx_inc[DATA_W-1:0]);
            end
          end
        end

        S_FINISH, S_ABORT: begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      end_q     <= '0;
      idx_q     <= '0;
      mode_q    <= '0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      end_q     <= end_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign wr      = wr_q;
  assign addr    = addr_q;
  assign data    = data_q;

endmodule

// File: tb/tb_ram_filler.sv
// Bench for ram_filler: randomized ack/ena fills compared against a
// behavioural pattern model, plus directed pattern, abort, edge and reset cases.
module tb_ram_filler;

  logic        clk = 1'b0;
  logic        reset, ena, start, abort, ack;
  logic [24:0] start_addr, end_addr;
  logic [1:0]  mode;
  logic [7:0]  pattern;
  logic        busy, done, aborted, wr;
  logic [24:0] addr;
  logic [7:0]  data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] got_a[$];
  logic [7:0]  got_d[$];
  int r_unstable, r_gap;
  bit r_found, r_abt, r_done_after, r_wr_at_done, r_busy_at_done;

  always #5 clk = ~clk;

  ram_filler #(.ADDR_W(25), .DATA_W(8), .MODE_W(2)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .mode(mode),
    .pattern(pattern), .ack(ack), .busy(busy), .done(done),
    .aborted(aborted), .wr(wr), .addr(addr), .data(data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_data(input logic [1:0] md, input logic [7:0] pat,
                                          input logic [24:0] sa, input logic [24:0] a);
    logic [24:0] idx;
    idx = a - sa;
    case (md)
      2'd0:    return pat;
      2'd1:    return pat + idx[7:0];
      2'd2:    return a[7:0] ^ pat;
      default: return a[0] ? ~pat : pat;
    endcase
  endfunction

  // Number of captured writes that deviate from the in-order model sequence.
  function automatic int count_bad(input logic [24:0] sa, input logic [1:0] md,
                                   input logic [7:0] pat);
    int bad = 0;
    for (int i = 0; i < got_a.size(); i++) begin
      logic [24:0] ea;
      ea = sa + 25'(i);
      if (got_a[i] !== ea || got_d[i] !== exp_data(md, pat, sa, ea)) bad++;
    end
    return bad;
  endfunction

  // Drives one fill and records accepted writes and how it ended.
  task automatic run_fill(input logic [24:0] sa, input logic [24:0] ea,
                          input logic [1:0] md, input logic [7:0] pat,
                          input bit rnd, input int abort_n, input int budget);
    bit e, a, ab, hold;
    logic [24:0] pa;
    logic [7:0]  pd;
    int last_acc;
    got_a.delete();
    got_d.delete();
    r_unstable = 0; r_found = 0; r_abt = 0; r_gap = -1;
    r_wr_at_done = 0; r_busy_at_done = 0;
    start_addr = sa; end_addr = ea; mode = md; pattern = pat;
    start = 1; ena = 1; ack = 0; abort = 0;
    step();
    start = 0;
    hold = 0; pa = '0; pd = '0; last_acc = -1;
    for (int c = 0; c < budget && !r_found; c++) begin
      e  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      a  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ab = 0;
      start = 0;
      if (rnd) begin
        start_addr = 25'($urandom); end_addr = 25'($urandom);
        mode = 2'($urandom); pattern = 8'($urandom);
        if (wr === 1'b1 && busy === 1'b1) start = 1'($urandom_range(0, 1));
      end
      if (abort_n > 0 && wr === 1'b1 && got_a.size() == abort_n - 1) begin
        ab = 1; a = 1; e = 1;
      end
      ena = e; ack = a; abort = ab;
      if (hold && (wr !== 1'b1 || addr !== pa || data !== pd)) r_unstable++;
      if (done === 1'b1 && e) begin
        r_found = 1; r_abt = aborted; r_gap = c - last_acc;
        r_wr_at_done = wr; r_busy_at_done = busy;
      end
      if (wr === 1'b1 && e && a) begin
        got_a.push_back(addr);
        got_d.push_back(data);
        last_acc = c;
      end
      hold = (wr === 1'b1) && !(e && a);
      pa = addr; pd = data;
      step();
    end
    ena = 1; ack = 0; abort = 0; start = 0;
    r_done_after = done;
  endtask

  task automatic test_reset();
    reset = 1; ena = 0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", wr); end
    n_checks++; if (addr !== 25'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
    n_checks++; if (data !== 8'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data); end
    reset = 0; ena = 1;
    step();
  endtask

  task automatic test_legacy_erase();
    int bad;
    run_fill(25'h8000, 25'hFFFF, 2'd0, 8'hFF, 0, 0, 40000);
    bad = count_bad(25'h8000, 2'd0, 8'hFF);
    n_checks++; if (!r_found) begin n_fail++; $display("FAIL legacy_timeout got=no_done exp=done"); end
    n_checks++; if (got_a.size() != 32768) begin n_fail++; $display("FAIL legacy_count got=%0d exp=32768", got_a.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL legacy_seq got=%0d_bad exp=0", bad); end
    n_checks++; if (r_abt !== 1'b0) begin n_fail++; $display("FAIL legacy_aborted got=%b exp=0", r_abt); end
    n_checks++; if (r_gap != 1) begin n_fail++; $display("FAIL legacy_done_latency got=%0d exp=1", r_gap); end
    n_checks++; if (r_done_after !== 1'b0) begin n_fail++; $display("FAIL legacy_done_width got=%b exp=0", r_done_after); end
  endtask

  task automatic test_patterns();
    logic [7:0] tab [3][4];
    tab = '{'{8'hA5, 8'hA6, 8'hA7, 8'hA8},
            '{8'hB5, 8'hB4, 8'hB7, 8'hB6},
            '{8'hA5, 8'h5A, 8'hA5, 8'h5A}};
    for (int m = 0; m < 3; m++) begin
      run_fill(25'h10, 25'h13, 2'(m + 1), 8'hA5, 0, 0, 50);
      n_checks++;
      if (got_a.size() != 4) begin
        n_fail++; $display("FAIL pattern_count mode=%0d got=%0d exp=4", m + 1, got_a.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (got_d[i] !== tab[m][i] || got_a[i] !== 25'h10 + 25'(i)) begin
            n_fail++;
            $display("FAIL pattern mode=%0d i=%0d got=%h@%h exp=%h@%h", m + 1, i,
                     got_d[i], got_a[i], tab[m][i], 25'h10 + 25'(i));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] sa, ea;
    logic [1:0]  md;
    logic [7:0]  pat;
    int bad;
    for (int t = 0; t < 5; t++) begin
      md = 2'($urandom); pat = 8'($urandom);
      if (t == 0) begin sa = 25'h100; ea = 25'h10F; end
      else begin sa = 25'($urandom_range(0, 4000)); ea = sa + 25'($urandom_range(0, 20)); end
      run_fill(sa, ea, md, pat, 1, 0, 600);
      bad = count_bad(sa, md, pat);
      n_checks++; if (!r_found) begin n_fail++; $display("FAIL bp_timeout t=%0d got=no_done exp=done", t); end
      n_checks++; if (got_a.size() != int'(ea - sa) + 1) begin n_fail++; $display("FAIL bp_count t=%0d got=%0d exp=%0d", t, got_a.size(), int'(ea - sa) + 1); end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_seq t=%0d got=%0d_bad exp=0", t, bad); end
      n_checks++; if (r_unstable != 0) begin n_fail++; $display("FAIL bp_stable t=%0d got=%0d exp=0", t, r_unstable); end
      n_checks++; if (r_abt !== 1'b0) begin n_fail++; $display("FAIL bp_aborted t=%0d got=%b exp=0", t, r_abt); end
    end
  endtask

  task automatic test_abort();
    int bad;
    run_fill(25'h0, 25'hFF, 2'd1, 8'h3C, 0, 5, 600);
    bad = count_bad(25'h0, 2'd1, 8'h3C);
    n_checks++; if (got_a.size() != 5) begin n_fail++; $display("FAIL abort_count got=%0d exp=5", got_a.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_seq got=%0d_bad exp=0", bad); end
    n_checks++; if (r_gap != 1) begin n_fail++; $display("FAIL abort_done_latency got=%0d exp=1", r_gap); end
    n_checks++; if (r_wr_at_done !== 1'b0) begin n_fail++; $display("FAIL abort_wr got=%b exp=0", r_wr_at_done); end
    n_checks++; if (r_abt !== 1'b1) begin n_fail++; $display("FAIL abort_aborted got=%b exp=1", r_abt); end
    n_checks++; if (r_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", r_busy_at_done); end
    n_checks++; if (r_done_after !== 1'b0) begin n_fail++; $display("FAIL abort_done_width got=%b exp=0", r_done_after); end
  endtask

  task automatic test_edges();
    run_fill(25'h1FFFFFF, 25'h1FFFFFF, 2'd0, 8'h77, 0, 0, 20);
    n_checks++; if (got_a.size() != 1) begin n_fail++; $display("FAIL top_count got=%0d exp=1", got_a.size()); end
    n_checks++; if (!r_found || r_abt !== 1'b0) begin n_fail++; $display("FAIL top_done got=%b/%b exp=1/0", r_found, r_abt); end
    n_checks++; if (addr !== 25'h1FFFFFF || data !== 8'h77) begin n_fail++; $display("FAIL top_hold got=%h/%h exp=1ffffff/77", addr, data); end
    run_fill(25'h5, 25'h4, 2'd0, 8'h11, 0, 0, 20);
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL empty_count got=%0d exp=0", got_a.size()); end
    n_checks++; if (!r_found || r_abt !== 1'b1) begin n_fail++; $display("FAIL empty_done got=%b/%b exp=1/1", r_found, r_abt); end
    n_checks++; if (r_gap != 1) begin n_fail++; $display("FAIL empty_latency got=%0d exp=1", r_gap); end
  endtask

  task automatic test_idle_abort_and_start();
    abort = 1; ena = 1; start = 0; ack = 0;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0 || wr !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_abort got=%b%b%b exp=000", busy, wr, done); end
    start_addr = 25'h30; end_addr = 25'h31; mode = 2'd2; pattern = 8'h0F; start = 1;
    step();
    start = 0; abort = 0;
    n_checks++; if (wr !== 1'b1 || busy !== 1'b1 || addr !== 25'h30 || data !== 8'h3F) begin n_fail++; $display("FAIL start_with_abort got=%b%b %h %h exp=11 30 3f", wr, busy, addr, data); end
    ack = 1;
    step();
    n_checks++; if (wr !== 1'b1 || addr !== 25'h31 || data !== 8'h3E) begin n_fail++; $display("FAIL second_write got=%b %h %h exp=1 31 3e", wr, addr, data); end
    step();
    ack = 0;
    n_checks++; if (done !== 1'b1 || aborted !== 1'b0 || wr !== 1'b0) begin n_fail++; $display("FAIL finish got=%b%b%b exp=100", done, aborted, wr); end
    step();
  endtask

  task automatic test_done_hold();
    start_addr = 25'h7; end_addr = 25'h7; mode = 2'd0; pattern = 8'h42;
    start = 1; ena = 1; ack = 0;
    step();
    start = 0; ack = 1;
    step();
    ack = 0; ena = 0;
    repeat (3) step();
    n_checks++; if (done !== 1'b1 || aborted !== 1'b0) begin n_fail++; $display("FAIL done_hold got=%b%b exp=10", done, aborted); end
    ena = 1;
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_clear got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_fill();
    int seen;
    bit dseen;
    start_addr = 25'h40; end_addr = 25'h4F; mode = 2'd1; pattern = 8'h10;
    start = 1; ena = 1; ack = 0;
    step();
    start = 0; ack = 1; seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      if (wr === 1'b1) seen++;
      step();
    end
    reset = 1;
    step();
    reset = 0; ack = 0;
    n_checks++; if (wr !== 1'b0 || busy !== 1'b0 || addr !== 25'h0 || data !== 8'h0 || done !== 1'b0 || aborted !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs got=%b%b %h %h %b%b exp=00 0 0 00", wr, busy, addr, data, done, aborted); end
    dseen = 0;
    repeat (4) begin step(); if (done === 1'b1 || wr === 1'b1) dseen = 1; end
    n_checks++; if (dseen) begin n_fail++; $display("FAIL midreset_no_done got=activity exp=idle"); end
    run_fill(25'h40, 25'h4F, 2'd1, 8'h10, 0, 0, 100);
    n_checks++; if (got_a.size() != 16 || count_bad(25'h40, 2'd1, 8'h10) != 0)
      begin n_fail++; $display("FAIL midreset_refill got=%0d_writes exp=16_in_order", got_a.size()); end
  endtask

  initial begin
    reset = 1; ena = 0; start = 0; abort = 0; ack = 0;
    start_addr = '0; end_addr = '0; mode = '0; pattern = '0;
    step();
    test_reset();
    test_patterns();
    test_backpressure();
    test_abort();
    test_edges();
    test_idle_abort_and_start();
    test_done_hold();
    test_reset_mid_fill();
    test_legacy_erase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
